filter_glb_loader: RTL and testbench

//  Write-side feeder for the filter global buffer. Accepts a stream of DATA_WIDTH filter

---
 rtl/filter_glb_loader.sv | 203 ++++++++++++++++++++
 tb/tb_filter_glb_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_glb_loader.sv
// ----------------------------------------------------------------------------
// filter_glb_loader
//
// Write-side feeder for the filter global buffer (GLB). Filter weights arrive
// one per cycle on a valid/ready stream. Four consecutive weights are packed
// into one FIFO_WIDTH word and written to the GLB starting at a programmed,
// word-aligned base address. Lane k of a packed word holds the weight whose
// element address has [1:0]==k.
//
// Optional feature macro: FILTER_LOADER_CHECKSUM_EN
//   When defined, adds output 'checksum': the modulo-2^DATA_WIDTH running sum
//   of all weights accepted in the current load. It is cleared on an accepted
//   start and stays stable from done until the next start.
//
// Ports
//   core_clk    in   clock, all logic on rising edge
//   core_rst_n  in   asynchronous active-low reset
//   start       in   one-cycle pulse, begin a load (sampled only when idle)
//   base_addr   in   first weight address, bits [1:0] ignored
//   num_elems   in   number of weights to load, 0..DEPTH
//   in_data     in   weight from upstream
//   in_valid    in   in_data valid
//   in_ready    out  loader accepts in_data this cycle
//   we          out  GLB write enable, one cycle per packed word
//   waddr       out  GLB write address (word aligned)
//   wdata       out  packed word, lane k in [DATA_WIDTH*k +: DATA_WIDTH]
//   busy        out  load in progress
//   done        out  one-cycle pulse, load finished
//   checksum    out  (FILTER_LOADER_CHECKSUM_EN only) running weight sum
// ----------------------------------------------------------------------------
module filter_glb_loader #(
   parameter int FIFO_WIDTH = 64,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 884736,
   parameter int ADDR       = $clog2(DEPTH)
) (
   input  logic                  core_clk,
   input  logic                  core_rst_n,
   input  logic                  start,
   input  logic [ADDR-1:0]       base_addr,
   input  logic [ADDR:0]         num_elems,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  we,
   output logic [ADDR-1:0]       waddr,
   output logic [FIFO_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done
`ifdef FILTER_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   localparam int LANES = FIFO_WIDTH / DATA_WIDTH;
   localparam int IDX_W = $clog2(LANES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_LAST = 2'd2
   } state_t;

   state_t                  state_q, state_d;

   logic [IDX_W-1:0]        idx_q;
   logic [ADDR:0]           rem_q;
   logic [ADDR-1:0]         word_addr_q;
   logic [DATA_WIDTH-1:0]   pack_q [LANES];

   logic                    we_q;
   logic [ADDR-1:0]         waddr_q;
   logic [FIFO_WIDTH-1:0]   wdata_q;
   logic                    done_q;

   logic                    accept;
   logic                    start_ok;
   logic                    last_elem;
   logic                    word_done;
   logic [DATA_WIDTH-1:0]   pack_merged [LANES];
   logic [FIFO_WIDTH-1:0]   word_flat;
   logic [ADDR:0]           addr_inc;
   logic [ADDR-1:0]         addr_next;
   logic [ADDR-1:0]         base_aligned;

   assign accept    = in_valid & in_ready;
   assign start_ok  = (state_q == S_IDLE) & start;
   assign last_elem = (rem_q == (ADDR+1)'(1));
   // A word is complete when its top lane fills or the load runs out of weights.
   assign word_done = accept & ((idx_q == IDX_W'(LANES-1)) | last_elem);

   // Low address bits are dropped so every GLB write is word aligned.
   assign base_aligned = base_addr & ~(ADDR'(LANES-1));

   // Next word address; wraps to 0 at the end of the buffer.
   assign addr_inc  = {1'b0, word_addr_q} + (ADDR+1)'(LANES);
   assign addr_next = (addr_inc >= (ADDR+1)'(DEPTH)) ? '0 : addr_inc[ADDR-1:0];

   // The weight being accepted is merged into its lane so a completed word
   // can be copied to the output register in the same cycle.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign pack_merged[gi] = (accept && (idx_q == IDX_W'(gi))) ? in_data : pack_q[gi];
      assign word_flat[gi*DATA_WIDTH +: DATA_WIDTH] = pack_merged[gi];
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start && (num_elems != '0)) state_d = S_LOAD;
         S_LOAD: if (accept && last_elem)        state_d = S_LAST;
         S_LAST: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_LAST: busy = 1'b1;
         default: ;
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         idx_q       <= '0;
         rem_q       <= '0;
         word_addr_q <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < LANES; i++) pack_q[i] <= '0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;

         if (start_ok) begin
            word_addr_q <= base_aligned;
            rem_q       <= num_elems;
            idx_q       <= '0;
            for (int i = 0; i < LANES; i++) pack_q[i] <= '0;
            // Zero-length load finishes immediately without any write.
            if (num_elems == '0) done_q <= 1'b1;
         end

         if (accept) begin
            rem_q <= rem_q - (ADDR+1)'(1);
            idx_q <= idx_q + IDX_W'(1);
            if (word_done) begin
               we_q        <= 1'b1;
               waddr_q     <= word_addr_q;
               wdata_q     <= word_flat;
               word_addr_q <= addr_next;
               for (int i = 0; i < LANES; i++) pack_q[i] <= '0;
               if (last_elem) done_q <= 1'b1;
            end else begin
               for (int i = 0; i < LANES; i++) pack_q[i] <= pack_merged[i];
            end
         end
      end
   end

   assign we    = we_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;
   assign done  = done_q;

`ifdef FILTER_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q;

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         sum_q <= '0;
      end else if (start_ok) begin
         sum_q <= '0;
      end else if (accept) begin
         sum_q <= sum_q + in_data;
      end
   end

   assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_filter_glb_loader.sv
module tb_filter_glb_loader;

   localparam int FIFO_WIDTH = 64;
   localparam int DATA_WIDTH = 16;
   localparam int DEPTH      = 884736;
   localparam int ADDR       = 20;

   logic                  core_clk = 1'b0;
   logic                  core_rst_n = 1'b0;
   logic                  start = 1'b0;
   logic [ADDR-1:0]       base_addr = '0;
   logic [ADDR:0]         num_elems = '0;
   logic [DATA_WIDTH-1:0] in_data = '0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  we;
   logic [ADDR-1:0]       waddr;
   logic [FIFO_WIDTH-1:0] wdata;
   logic                  busy;
   logic                  done;
`ifdef FILTER_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum;
`endif

   filter_glb_loader #(
      .FIFO_WIDTH(FIFO_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .core_clk   (core_clk),
      .core_rst_n (core_rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .num_elems  (num_elems),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done)
`ifdef FILTER_LOADER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 core_clk = ~core_clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   typedef struct {
      logic [ADDR-1:0]       addr;
      logic [FIFO_WIDTH-1:0] data;
      bit                    last;
      int                    due;
   } exp_t;

   exp_t                  sb_q [$];
   int                    cyc = 0;
   int                    zero_due = -1;
   bit                    prev_done = 1'b0;
   int                    m_idx = 0;
   int                    m_rem = 0;
   logic [ADDR-1:0]       m_addr = '0;
   logic [FIFO_WIDTH-1:0] m_pack = '0;
   logic [DATA_WIDTH-1:0] m_sum = '0;

   always @(negedge core_clk) begin
      cyc++;
      if (!core_rst_n) begin
         sb_q.delete();
         zero_due  = -1;
         prev_done = 1'b0;
         m_idx     = 0;
         m_rem     = 0;
         m_pack    = '0;
         m_sum     = '0;
      end else begin
         bit   exp_done;
         exp_t e;
         exp_done = (zero_due == cyc);
         if (we) begin
            if (sb_q.size() == 0) begin
               chk("we_unexpected", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("waddr", 64'(waddr), 64'(e.addr));
               chk("wdata", wdata, e.data);
               chk("we_latency", 64'(cyc), 64'(e.due));
               chk("done_with_we", 64'(done), 64'(e.last));
               $display("[TB] write addr=0x%05h data=0x%016h done=%0d", waddr, wdata, done);
            end
         end else begin
            if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
               chk("we_missing", 0, 1);
               void'(sb_q.pop_front());
            end
            if (done || exp_done) chk("done_pulse", 64'(done), 64'(exp_done));
         end
         if (prev_done) chk("busy_after_done", 64'(busy), 0);
`ifdef FILTER_LOADER_CHECKSUM_EN
         if (done) chk("checksum_at_done", 64'(checksum), 64'(m_sum));
`endif
         prev_done = done;

         if (start && !busy) begin
            m_addr = base_addr & ~ADDR'(3);
            m_rem  = int'(num_elems);
            m_idx  = 0;
            m_pack = '0;
            m_sum  = '0;
            if (num_elems == 0) zero_due = cyc + 1;
         end
         if (in_valid && in_ready) begin
            m_pack[m_idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
            m_sum = m_sum + in_data;
            m_rem--;
            if (m_idx == 3 || m_rem == 0) begin
               e.addr = m_addr;
               e.data = m_pack;
               e.last = (m_rem == 0);
               e.due  = cyc + 1;
               sb_q.push_back(e);
               m_pack = '0;
               m_addr = (int'(m_addr) + 4 >= DEPTH) ? '0 : m_addr + ADDR'(4);
            end
            m_idx = (m_idx + 1) % 4;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_start(input logic [ADDR-1:0] base, input int num);
      @(posedge core_clk); #1;
      start     = 1'b1;
      base_addr = base;
      num_elems = (ADDR+1)'(num);
      @(posedge core_clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [DATA_WIDTH-1:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge core_clk);
      while (!in_ready && n < 20) begin
         @(negedge core_clk);
         n++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
      @(posedge core_clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge core_clk);
      while ((busy || sb_q.size() != 0) && n < 40) begin
         @(negedge core_clk);
         n++;
      end
      chk("sb_drain", 64'(sb_q.size()), 0);
      chk("busy_end", 64'(busy), 0);
   endtask

   task automatic load(input logic [ADDR-1:0] base, input int num,
                       input logic [DATA_WIDTH-1:0] first, input logic [DATA_WIDTH-1:0] step,
                       input bit gaps);
      $display("[TB] load base=0x%05h num=%0d gaps=%0d", base, num, gaps);
      pulse_start(base, num);
      if (num != 0) begin
         @(negedge core_clk);
         chk("busy_in_load", 64'(busy), 1);
         @(posedge core_clk); #1;
      end
      for (int i = 0; i < num; i++) begin
         send(first + DATA_WIDTH'(i) * step);
         if (gaps) begin
            @(posedge core_clk); #1;
         end
      end
      wait_idle();
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge core_clk);
      chk({tag, "_in_ready"}, 64'(in_ready), 0);
      chk({tag, "_we"}, 64'(we), 0);
      chk({tag, "_waddr"}, 64'(waddr), 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_done"}, 64'(done), 0);
   endtask

   initial begin
      check_reset_state("rst");
      repeat (2) @(posedge core_clk);
      #1 core_rst_n = 1'b1;

      // back-to-back and short final word
      load(20'd0, 8, 16'd1, 16'd1, 1'b0);
      load(20'd16, 6, 16'd1, 16'd1, 1'b0);

      // bubbles between weights
      load(20'd0, 8, 16'd1, 16'd1, 1'b1);

      // zero-length load, stray in_valid while idle must be ignored
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      load(20'd0, 0, 16'd0, 16'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge core_clk);
         chk("zero_in_ready", 64'(in_ready), 0);
      end
      in_valid = 1'b0;

      // reset in the middle of a load
      $display("[TB] reset mid-load");
      pulse_start(20'd0, 8);
      send(16'd1);
      send(16'd2);
      core_rst_n = 1'b0;
      check_reset_state("midrst");
      @(posedge core_clk); #1;
      core_rst_n = 1'b1;
      load(20'd0, 4, 16'd9, 16'd1, 1'b0);

      // address wrap, aligned and unaligned base
      load(20'(DEPTH - 4), 8, 16'h0100, 16'd3, 1'b0);
      load(20'(DEPTH - 1), 8, 16'h0200, 16'd5, 1'b0);

      // start while busy is ignored
      $display("[TB] start while busy");
      pulse_start(20'd32, 4);
      @(posedge core_clk); #1;
      start = 1'b1; base_addr = 20'd64; num_elems = 21'd2;
      @(posedge core_clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) send(16'h0A00 + 16'(i));
      wait_idle();

`ifdef FILTER_LOADER_CHECKSUM_EN
      load(20'd0, 8, 16'd1, 16'd1, 1'b0);
      chk("cksum_36", 64'(checksum), 64'd36);
      load(20'd0, 2, 16'hFFFF, 16'd0, 1'b0);
      chk("cksum_fffe", 64'(checksum), 64'hFFFE);
`endif

      repeat (3) @(negedge core_clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
